// File: rtl/i2c_imu_responder.sv
// rtl/i2c_imu_responder.sv - I2C target emulating an IMU register file; optional clock stretch via I2C_RESPONDER_STRETCH_EN
module i2c_imu_responder #(
   parameter logic [6:0] DEV_ADDR       = 7'h28,
   parameter int         REG_DEPTH      = 64,
   parameter int         FILTER_LEN     = 3,
   parameter int         STRETCH_CYCLES = 16
) (
   input  logic                         sys_clk,
   input  logic                         resetn,
   input  logic                         scl_in,
   input  logic                         sda_in,
   output logic                         sda_oe,
   output logic                         scl_oe,
   input  logic                         reg_wr_en,
   input  logic [$clog2(REG_DEPTH)-1:0] reg_wr_addr,
   input  logic [7:0]                   reg_wr_data,
   input  logic [$clog2(REG_DEPTH)-1:0] reg_rd_addr,
   output logic [7:0]                   reg_rd_data,
   output logic                         i2c_wr_strobe,
   output logic [$clog2(REG_DEPTH)-1:0] i2c_wr_addr,
   output logic                         busy
);

   localparam int AW = $clog2(REG_DEPTH);
   localparam int FW = $clog2(FILTER_LEN + 1);

   typedef enum logic [3:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
      S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_WAIT_STOP
   } state_t;

   logic [1:0]    r_scl_s, r_sda_s;
   logic [FW-1:0] r_scl_cnt, r_sda_cnt;
   logic          r_scl_f, r_sda_f, r_scl_d, r_sda_d;
   logic          w_scl_rise, w_scl_fall, w_start, w_stop;

   state_t        r_state, w_state_nxt;
   logic [3:0]    r_cnt, w_cnt_nxt;
   logic [7:0]    r_shift, w_shift_nxt;
   logic [AW-1:0] r_ptr, w_ptr_nxt, w_ptr_inc;
   logic          r_sda_oe, w_sda_oe_nxt;
   logic          r_busy, w_busy_nxt;
   logic          r_ack, w_ack_nxt;
   logic          w_commit, w_load;
   logic          r_wr_strobe;
   logic [AW-1:0] r_wr_addr;
   logic [7:0]    r_rd_data;
   logic [7:0]    r_regs [REG_DEPTH];

   // two-flop synchronizers for the raw pad levels (bus idles high)
   always_ff @(posedge sys_clk or negedge resetn) begin
      if (!resetn) begin
         r_scl_s <= 2'b11;
         r_sda_s <= 2'b11;
      end else begin
         r_scl_s <= {r_scl_s[0], scl_in};
         r_sda_s <= {r_sda_s[0], sda_in};
      end
   end

   // glitch filter: a new level is accepted only after FILTER_LEN consecutive samples
   always_ff @(posedge sys_clk or negedge resetn) begin
      if (!resetn) begin
         r_scl_f   <= 1'b1;
         r_sda_f   <= 1'b1;
         r_scl_d   <= 1'b1;
         r_sda_d   <= 1'b1;
         r_scl_cnt <= '0;
         r_sda_cnt <= '0;
      end else begin
         r_scl_d <= r_scl_f;
         r_sda_d <= r_sda_f;
         if (r_scl_s[1] == r_scl_f) begin
            r_scl_cnt <= '0;
         end else if (r_scl_cnt == FW'(FILTER_LEN - 1)) begin
            r_scl_f   <= r_scl_s[1];
            r_scl_cnt <= '0;
         end else begin
            r_scl_cnt <= r_scl_cnt + 1'b1;
         end
         if (r_sda_s[1] == r_sda_f) begin
            r_sda_cnt <= '0;
         end else if (r_sda_cnt == FW'(FILTER_LEN - 1)) begin
            r_sda_f   <= r_sda_s[1];
            r_sda_cnt <= '0;
         end else begin
            r_sda_cnt <= r_sda_cnt + 1'b1;
         end
      end
   end

   assign w_scl_rise = r_scl_f & ~r_scl_d;
   assign w_scl_fall = ~r_scl_f & r_scl_d;
   assign w_start    = r_scl_f & r_scl_d & r_sda_d & ~r_sda_f;
   assign w_stop     = r_scl_f & r_scl_d & ~r_sda_d & r_sda_f;
   assign w_ptr_inc  = r_ptr + AW'(1);

   // protocol state register and byte datapath
   always_ff @(posedge sys_clk or negedge resetn) begin
      if (!resetn) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_shift     <= '0;
         r_ptr       <= '0;
         r_sda_oe    <= 1'b0;
         r_busy      <= 1'b0;
         r_ack       <= 1'b0;
         r_wr_strobe <= 1'b0;
         r_wr_addr   <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_shift     <= w_shift_nxt;
         r_ptr       <= w_ptr_nxt;
         r_sda_oe    <= w_sda_oe_nxt;
         r_busy      <= w_busy_nxt;
         r_ack       <= w_ack_nxt;
         r_wr_strobe <= w_commit;
         if (w_commit) r_wr_addr <= r_ptr;
      end
   end

   // next-state logic: bits shift on SCL rise, SDA drive and state changes on SCL fall
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_shift_nxt  = r_shift;
      w_ptr_nxt    = r_ptr;
      w_sda_oe_nxt = r_sda_oe;
      w_busy_nxt   = r_busy;
      w_ack_nxt    = r_ack;
      w_commit     = 1'b0;
      w_load       = 1'b0;
      if (w_start) begin
         w_state_nxt  = S_ADDR;
         w_cnt_nxt    = '0;
         w_sda_oe_nxt = 1'b0;
         w_busy_nxt   = 1'b0;
      end else if (w_stop) begin
         w_state_nxt  = S_IDLE;
         w_cnt_nxt    = '0;
         w_sda_oe_nxt = 1'b0;
         w_busy_nxt   = 1'b0;
      end else if (w_scl_rise) begin
         if (r_state != S_IDLE && r_state != S_WAIT_STOP) w_cnt_nxt = r_cnt + 4'd1;
         case (r_state)
            S_ADDR, S_PTR, S_WR_DATA: w_shift_nxt = {r_shift[6:0], r_sda_f};
            S_RD_DATA:                w_shift_nxt = {r_shift[6:0], 1'b0};
            S_RD_ACK:                 w_ack_nxt   = r_sda_f;
            default:                  ;
         endcase
      end else if (w_scl_fall) begin
         case (r_state)
            S_ADDR: if (r_cnt == 4'd8) begin
               w_cnt_nxt = '0;
               if (r_shift[7:1] == DEV_ADDR) begin
                  w_state_nxt  = S_ADDR_ACK;
                  w_sda_oe_nxt = 1'b1;
                  w_busy_nxt   = 1'b1;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
            S_ADDR_ACK: if (r_cnt != 4'd0) begin
               w_cnt_nxt = '0;
               if (r_shift[0]) begin
                  w_state_nxt  = S_RD_DATA;
                  w_load       = 1'b1;
                  w_shift_nxt  = r_regs[r_ptr];
                  w_sda_oe_nxt = ~r_regs[r_ptr][7];
               end else begin
                  w_state_nxt  = S_PTR;
                  w_sda_oe_nxt = 1'b0;
               end
            end
            S_PTR: if (r_cnt == 4'd8) begin
               w_cnt_nxt    = '0;
               w_ptr_nxt    = r_shift[AW-1:0];
               w_state_nxt  = S_PTR_ACK;
               w_sda_oe_nxt = 1'b1;
            end
            S_PTR_ACK: if (r_cnt != 4'd0) begin
               w_cnt_nxt    = '0;
               w_state_nxt  = S_WR_DATA;
               w_sda_oe_nxt = 1'b0;
            end
            S_WR_DATA: if (r_cnt == 4'd8) begin
               w_cnt_nxt    = '0;
               w_state_nxt  = S_WR_ACK;
               w_sda_oe_nxt = 1'b1;
            end
            S_WR_ACK: if (r_cnt != 4'd0) begin
               w_cnt_nxt    = '0;
               w_commit     = 1'b1;
               w_ptr_nxt    = w_ptr_inc;
               w_state_nxt  = S_WR_DATA;
               w_sda_oe_nxt = 1'b0;
            end
            S_RD_DATA: begin
               if (r_cnt == 4'd8) begin
                  w_cnt_nxt    = '0;
                  w_state_nxt  = S_RD_ACK;
                  w_sda_oe_nxt = 1'b0;
               end else begin
                  w_sda_oe_nxt = ~r_shift[7];
               end
            end
            S_RD_ACK: if (r_cnt != 4'd0) begin
               w_cnt_nxt = '0;
               if (!r_ack) begin
                  w_ptr_nxt    = w_ptr_inc;
                  w_state_nxt  = S_RD_DATA;
                  w_load       = 1'b1;
                  w_shift_nxt  = r_regs[w_ptr_inc];
                  w_sda_oe_nxt = ~r_regs[w_ptr_inc][7];
               end else begin
                  w_state_nxt  = S_WAIT_STOP;
                  w_sda_oe_nxt = 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // register file: I2C commit first so a same-cycle host write to the same address wins
   always_ff @(posedge sys_clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < REG_DEPTH; i++) r_regs[i] <= 8'h00;
      end else begin
         if (w_commit) r_regs[r_ptr] <= r_shift;
         if (reg_wr_en) r_regs[reg_wr_addr] <= reg_wr_data;
      end
   end

   // host read port, one cycle latency
   always_ff @(posedge sys_clk or negedge resetn) begin
      if (!resetn) r_rd_data <= 8'h00;
      else         r_rd_data <= r_regs[reg_rd_addr];
   end

`ifdef I2C_RESPONDER_STRETCH_EN
   localparam int SW = $clog2(STRETCH_CYCLES + 1);
   logic [SW-1:0] r_stretch_cnt;
   logic          r_scl_oe;

   // hold SCL low for STRETCH_CYCLES after each read byte load
   always_ff @(posedge sys_clk or negedge resetn) begin
      if (!resetn) begin
         r_stretch_cnt <= '0;
         r_scl_oe      <= 1'b0;
      end else if (w_load) begin
         r_stretch_cnt <= SW'(STRETCH_CYCLES);
         r_scl_oe      <= 1'b1;
      end else if (r_stretch_cnt != '0) begin
         r_stretch_cnt <= r_stretch_cnt - 1'b1;
         if (r_stretch_cnt == SW'(1)) r_scl_oe <= 1'b0;
      end
   end

   assign scl_oe = r_scl_oe;
`else
   logic w_load_unused;
   assign w_load_unused = w_load;
   assign scl_oe = 1'b0;
`endif

   assign sda_oe        = r_sda_oe;
   assign busy          = r_busy;
   assign reg_rd_data   = r_rd_data;
   assign i2c_wr_strobe = r_wr_strobe;
   assign i2c_wr_addr   = r_wr_addr;

endmodule

// File: tb/tb_i2c_imu_responder.sv
// tb/tb_i2c_imu_responder.sv - scoreboard bench for i2c_imu_responder
module tb_i2c_imu_responder;

   localparam int Q = 8;

   logic       sys_clk = 1'b0;
   logic       resetn  = 1'b0;
   logic       m_scl   = 1'b1;
   logic       m_sda   = 1'b1;
   logic       scl_in, sda_in, sda_oe, scl_oe;
   logic       reg_wr_en = 1'b0;
   logic [5:0] reg_wr_addr = '0;
   logic [7:0] reg_wr_data = '0;
   logic [5:0] reg_rd_addr = '0;
   logic [7:0] reg_rd_data;
   logic       i2c_wr_strobe;
   logic [5:0] i2c_wr_addr;
   logic       busy;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] model_regs [64];
   int         mptr;
   int         exp_strobe_q [$];
   logic [7:0] exp_rd_q [$];
   logic       rd_req = 1'b0;
   logic       rd_pend = 1'b0;
   logic       oe_seen = 1'b0;

   assign scl_in = m_scl & ~scl_oe;
   assign sda_in = m_sda & ~sda_oe;

   i2c_imu_responder dut (
      .sys_clk(sys_clk), .resetn(resetn), .scl_in(scl_in), .sda_in(sda_in),
      .sda_oe(sda_oe), .scl_oe(scl_oe), .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr),
      .reg_wr_data(reg_wr_data), .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data),
      .i2c_wr_strobe(i2c_wr_strobe), .i2c_wr_addr(i2c_wr_addr), .busy(busy)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   always @(posedge sys_clk) rd_pend <= rd_req;

   // monitor: compares DUT outputs against queued expectations
   always @(negedge sys_clk) begin
      if (sda_oe) oe_seen <= 1'b1;
      if (rd_pend) begin
         if (exp_rd_q.size() == 0) check("host_rd_unexpected", 1, 0);
         else check("host_rd_data", reg_rd_data, exp_rd_q.pop_front());
      end
      if (resetn && i2c_wr_strobe) begin
         if (exp_strobe_q.size() == 0) check("wr_strobe_unexpected", 1, 0);
         else check("wr_strobe_addr", i2c_wr_addr, exp_strobe_q.pop_front());
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   task automatic host_write(input int a, input logic [7:0] d);
      reg_wr_en = 1'b1; reg_wr_addr = a[5:0]; reg_wr_data = d;
      tick(1);
      reg_wr_en = 1'b0;
      model_regs[a] = d;
   endtask

   task automatic host_read(input int a);
      reg_rd_addr = a[5:0];
      exp_rd_q.push_back(model_regs[a]);
      rd_req = 1'b1;
      tick(1);
      rd_req = 1'b0;
      tick(1);
   endtask

   task automatic bit_out(input logic b, input logic glitch);
      m_sda = b; tick(Q);
      m_scl = 1'b1; tick(Q);
      if (glitch) begin
         m_sda = ~b; tick(1); m_sda = b;
      end
      tick(Q);
      m_scl = 1'b0; tick(Q);
   endtask

   task automatic bit_in(output logic b);
      m_sda = 1'b1; tick(Q);
      m_scl = 1'b1; tick(Q);
      b = sda_in; tick(Q);
      m_scl = 1'b0; tick(Q);
   endtask

   task automatic i2c_start();
      if (!m_scl) begin
         m_sda = 1'b1; tick(Q);
         m_scl = 1'b1; tick(Q);
      end
      m_sda = 1'b0; tick(Q);
      m_scl = 1'b0; tick(Q);
   endtask

   task automatic i2c_stop();
      m_sda = 1'b0; tick(Q);
      m_scl = 1'b1; tick(Q);
      m_sda = 1'b1; tick(2 * Q);
   endtask

   task automatic write_byte(input logic [7:0] b, input logic [7:0] gmask, output logic ack);
      for (int i = 7; i >= 0; i--) bit_out(b[i], gmask[i]);
      bit_in(ack);
   endtask

   task automatic read_byte(input logic nack, output logic [7:0] d);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         bit_in(b);
         d[i] = b;
      end
      bit_out(nack, 1'b0);
   endtask

   task automatic write_txn(input logic [7:0] p, input logic [7:0] d [4], input int n,
                            input logic [7:0] gmask);
      logic a;
      i2c_start();
      write_byte(8'h50, 8'h00, a); check("wr_addr_ack", a, 0);
      write_byte(p, 8'h00, a);     check("wr_ptr_ack", a, 0);
      mptr = p % 64;
      for (int k = 0; k < n; k++) begin
         exp_strobe_q.push_back(mptr);
         model_regs[mptr] = d[k];
         write_byte(d[k], (k == 0) ? gmask : 8'h00, a);
         check("wr_data_ack", a, 0);
         check("busy_in_write", busy, 1);
         mptr = (mptr + 1) % 64;
      end
      i2c_stop();
      check("busy_after_wr_stop", busy, 0);
   endtask

   task automatic read_body(input int n);
      logic       a;
      logic [7:0] d;
      write_byte(8'h51, 8'h00, a); check("rd_addr_ack", a, 0);
      for (int k = 0; k < n; k++) begin
         read_byte(k == n - 1, d);
         check("rd_data", d, model_regs[mptr]);
         if (k < n - 1) mptr = (mptr + 1) % 64;
      end
      check("busy_before_rd_stop", busy, 1);
      i2c_stop();
      check("busy_after_rd_stop", busy, 0);
   endtask

   task automatic read_from(input logic [7:0] p, input int n);
      logic a;
      i2c_start();
      write_byte(8'h50, 8'h00, a); check("rdp_addr_ack", a, 0);
      write_byte(p, 8'h00, a);     check("rdp_ptr_ack", a, 0);
      mptr = p % 64;
      i2c_start();
      read_body(n);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       a, seen;
      logic [7:0] d [4];
      logic [7:0] cbyte;
      for (int i = 0; i < 64; i++) model_regs[i] = 8'h00;
      mptr = 0;
      tick(3);
      check("rst_sda_oe", sda_oe, 0);
      check("rst_scl_oe", scl_oe, 0);
      check("rst_busy", busy, 0);
      check("rst_strobe", i2c_wr_strobe, 0);
      check("rst_wr_addr", i2c_wr_addr, 0);
      check("rst_rd_data", reg_rd_data, 0);
      resetn = 1'b1;
      tick(2);
      host_read(0);
      host_read(63);

      // preload and read back with repeated start, ACK then NACK
      host_write(8'h1A, 8'h34);
      host_write(8'h1B, 8'h12);
      read_from(8'h1A, 2);

      // auto-increment wraps from 63 to 0
      d[0] = 8'hAA; d[1] = 8'hBB; d[2] = 8'h00; d[3] = 8'h00;
      write_txn(8'h3F, d, 2, 8'h00);
      host_read(8'h3F);
      host_read(8'h00);

      // foreign address: no ACK, no drive, not busy
      oe_seen = 1'b0;
      i2c_start();
      write_byte(8'h52, 8'h00, a);
      check("foreign_nack", a, 1);
      check("foreign_busy", busy, 0);
      check("foreign_oe_seen", oe_seen, 0);
      i2c_stop();
      host_read(8'h3F);

      // one-cycle SDA glitches while SCL high on a 0 bit and a 1 bit
      d[0] = 8'h5A; d[1] = 8'hC3;
      write_txn(8'h10, d, 2, 8'hC0);
      host_read(8'h10);
      host_read(8'h11);

      // randomized traffic against the reference model
      for (int it = 0; it < 10; it++) begin
         int kind, p, n;
         kind = $urandom_range(0, 3);
         p    = $urandom_range(0, 255);
         n    = $urandom_range(1, 3);
         case (kind)
            0: begin
               for (int k = 0; k < n; k++) host_write($urandom_range(0, 63), 8'($urandom));
               host_read($urandom_range(0, 63));
            end
            1: begin
               for (int k = 0; k < 4; k++) d[k] = 8'($urandom);
               write_txn(8'(p), d, n, 8'h00);
               host_read((p + n - 1) % 64);
            end
            2: read_from(8'(p), n);
            default: begin
               i2c_start();
               read_body(n);
            end
         endcase
      end

      // asynchronous reset while the responder pulls SDA low for a read bit
      host_write(8'h20, 8'h00);
      i2c_start();
      write_byte(8'h50, 8'h00, a); check("rst_txn_ack0", a, 0);
      write_byte(8'h20, 8'h00, a); check("rst_txn_ack1", a, 0);
      i2c_start();
      write_byte(8'h51, 8'h00, a); check("rst_txn_ack2", a, 0);
      m_sda = 1'b1; tick(Q);
      m_scl = 1'b1; tick(Q);
      check("mid_read_sda_oe", sda_oe, 1);
      resetn = 1'b0;
      #1;
      check("async_rst_sda_oe", sda_oe, 0);
      check("async_rst_scl_oe", scl_oe, 0);
      check("async_rst_busy", busy, 0);
      check("async_rst_strobe", i2c_wr_strobe, 0);
      check("async_rst_wr_addr", i2c_wr_addr, 0);
      check("async_rst_rd_data", reg_rd_data, 0);
      tick(2);
      resetn = 1'b1;
      for (int i = 0; i < 64; i++) model_regs[i] = 8'h00;
      mptr = 0;
      tick(Q);
      host_read(8'h1A);

      // host write and I2C commit to reg 0x05 on the same edge
      cbyte = 8'h22;
      i2c_start();
      write_byte(8'h50, 8'h00, a); check("col_addr_ack", a, 0);
      write_byte(8'h05, 8'h00, a); check("col_ptr_ack", a, 0);
      for (int i = 7; i >= 0; i--) bit_out(cbyte[i], 1'b0);
      exp_strobe_q.push_back(5);
      model_regs[5] = 8'h11;
      mptr = 6;
      m_sda = 1'b1; tick(Q);
      m_scl = 1'b1; tick(Q);
      a = sda_in; check("col_data_ack", a, 0);
      tick(Q);
      reg_wr_en = 1'b1; reg_wr_addr = 6'h05; reg_wr_data = 8'h11;
      m_scl = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
         tick(1);
         seen = i2c_wr_strobe;
      end
      reg_wr_en = 1'b0;
      check("col_strobe_seen", seen, 1);
      tick(Q);
      i2c_stop();
      host_read(8'h05);
      host_read(8'h06);

      tick(4);
      check("strobe_queue_empty", exp_strobe_q.size(), 0);
      check("rd_queue_empty", exp_rd_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
